// File: rtl/pio_ctrl_pkg.sv
// Shared definitions for the PIO interrupt service controller: FSM state
// encoding and the register map of the edge-capture PIO slave it drives.
package pio_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT_CLR = 3'd0,
        ST_OFF      = 3'd1,
        ST_IDLE     = 3'd2,
        ST_RD_CAP   = 3'd3,
        ST_CHECK    = 3'd4,
        ST_CLR      = 3'd5,
        ST_HOLD     = 3'd6
    } state_t;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAP  = 2'd3;

    // Busy covers everything except the two resting states.
    function automatic logic state_is_busy(input state_t st);
        return !((st == ST_IDLE) || (st == ST_OFF));
    endfunction

endpackage

// File: rtl/pio_irq_service_ctrl.sv
// Avalon-MM master that configures one edge-capture PIO and services its
// interrupt without a CPU: read capture, clear it, count the event, then
// wait a holdoff window. The PIO mask follows the level input 'enable'.
// Optional feature macro: PIO_IRQ_TIMESTAMP_EN adds a free-running cycle
// counter and the last_ts output holding its value at each serviced event.
// Bus outputs are registered so every output is 0 (write_n 1) in reset;
// the command for a state is loaded on the edge that enters that state.
module pio_irq_service_ctrl
    import pio_ctrl_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int HOLDOFF      = 4,
    parameter int READ_LATENCY = 1,
    parameter int TS_W         = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [1:0]       m_address,
    output logic             m_chipselect,
    output logic             m_write_n,
    output logic [31:0]      m_writedata,
    input  logic [31:0]      m_readdata,
    input  logic             pio_irq,
    input  logic             enable,
    output logic             event_pulse,
    output logic [CNT_W-1:0] event_count,
    output logic [CNT_W-1:0] spurious_count,
    output logic             busy
`ifdef PIO_IRQ_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]  last_ts
`endif
);

    // A zero read latency still needs one cycle for the read command to reach the bus.
    localparam int RD_CYC    = (READ_LATENCY < 1) ? 1 : READ_LATENCY;
    localparam int WAIT_MAX  = (RD_CYC > HOLDOFF) ? RD_CYC : HOLDOFF;
    localparam int WAIT_W    = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] RD_LOAD   = WAIT_W'(RD_CYC - 1);
    localparam logic [WAIT_W-1:0] HOLD_LOAD = WAIT_W'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic [1:0]        addr_reg, addr_next;
    logic              cs_reg, cs_next;
    logic              write_n_reg, write_n_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic              busy_reg;
    logic              pulse_reg;
    logic [CNT_W-1:0]  event_count_reg, spurious_count_reg;
    logic              event_hit, spurious_hit;

    // Only bit 0 of the capture register is meaningful to this controller.
    logic rd_unused;
    assign rd_unused = ^m_readdata[31:1];

    // Next-state decode plus the bus command to present in the next state.
    always_comb begin
        state_next   = state_reg;
        wait_next    = wait_reg;
        cs_next      = 1'b0;
        write_n_next = 1'b1;
        addr_next    = ADDR_DATA;
        wdata_next   = 32'd0;
        event_hit    = 1'b0;
        spurious_hit = 1'b0;
        case (state_reg)
            ST_INIT_CLR: begin
                // First cycle after reset loads the clear; leave once it is on the bus.
                if (cs_reg && !write_n_reg) begin
                    state_next = ST_OFF;
                end else begin
                    cs_next      = 1'b1;
                    write_n_next = 1'b0;
                    addr_next    = ADDR_CAP;
                end
            end
            ST_OFF: begin
                if (enable) begin
                    state_next   = ST_IDLE;
                    cs_next      = 1'b1;
                    write_n_next = 1'b0;
                    addr_next    = ADDR_MASK;
                    wdata_next   = 32'd1;
                end
            end
            ST_IDLE: begin
                if (!enable) begin
                    state_next   = ST_OFF;
                    cs_next      = 1'b1;
                    write_n_next = 1'b0;
                    addr_next    = ADDR_MASK;
                end else if (pio_irq) begin
                    state_next = ST_RD_CAP;
                    wait_next  = RD_LOAD;
                    cs_next    = 1'b1;
                    addr_next  = ADDR_CAP;
                end
            end
            ST_RD_CAP: begin
                // Address stays on the bus until CHECK has sampled the data.
                cs_next   = 1'b1;
                addr_next = ADDR_CAP;
                if (wait_reg == '0) begin
                    state_next = ST_CHECK;
                end else begin
                    wait_next = wait_reg - 1'b1;
                end
            end
            ST_CHECK: begin
                if (m_readdata[0]) begin
                    event_hit    = 1'b1;
                    state_next   = ST_CLR;
                    cs_next      = 1'b1;
                    write_n_next = 1'b0;
                    addr_next    = ADDR_CAP;
                end else begin
                    spurious_hit = 1'b1;
                    state_next   = ST_IDLE;
                end
            end
            ST_CLR: begin
                if (HOLDOFF == 0) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_HOLD;
                    wait_next  = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (wait_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    wait_next = wait_reg - 1'b1;
                end
            end
            default: begin
                state_next = ST_INIT_CLR;
            end
        endcase
    end

    // State, bus command and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg          <= ST_INIT_CLR;
            wait_reg           <= '0;
            addr_reg           <= ADDR_DATA;
            cs_reg             <= 1'b0;
            write_n_reg        <= 1'b1;
            wdata_reg          <= 32'd0;
            busy_reg           <= 1'b0;
            pulse_reg          <= 1'b0;
            event_count_reg    <= '0;
            spurious_count_reg <= '0;
        end else begin
            state_reg   <= state_next;
            wait_reg    <= wait_next;
            addr_reg    <= addr_next;
            cs_reg      <= cs_next;
            write_n_reg <= write_n_next;
            wdata_reg   <= wdata_next;
            busy_reg    <= state_is_busy(state_next);
            pulse_reg   <= event_hit;
            if (event_hit) begin
                event_count_reg <= event_count_reg + 1'b1;
            end
            if (spurious_hit) begin
                spurious_count_reg <= spurious_count_reg + 1'b1;
            end
        end
    end

`ifdef PIO_IRQ_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_reg;
    logic [TS_W-1:0] last_ts_reg;

    // Free-running cycle counter, captured in the CHECK cycle of each real event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt_reg  <= '0;
            last_ts_reg <= '0;
        end else begin
            ts_cnt_reg <= ts_cnt_reg + 1'b1;
            if (event_hit) begin
                last_ts_reg <= ts_cnt_reg;
            end
        end
    end

    assign last_ts = last_ts_reg;
`endif

    assign m_address      = addr_reg;
    assign m_chipselect   = cs_reg;
    assign m_write_n      = write_n_reg;
    assign m_writedata    = wdata_reg;
    assign event_pulse    = pulse_reg;
    assign event_count    = event_count_reg;
    assign spurious_count = spurious_count_reg;
    assign busy           = busy_reg;

endmodule

// File: tb/tb_pio_irq_service_ctrl.sv
// Bench for pio_irq_service_ctrl: models the edge-capture PIO slave
// (registered readdata, clear beats a same-cycle edge) and keeps expected
// event / spurious counts from the directed and random stimulus applied.
module tb_pio_irq_service_ctrl;

    localparam int CNT_W   = 4;
    localparam int HOLDOFF = 4;
    localparam int RL      = 1;
    localparam int TS_W    = 32;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       m_address;
    logic             m_chipselect;
    logic             m_write_n;
    logic [31:0]      m_writedata;
    logic [31:0]      m_readdata;
    logic             pio_irq;
    logic             enable;
    logic             event_pulse;
    logic [CNT_W-1:0] event_count;
    logic [CNT_W-1:0] spurious_count;
    logic             busy;
`ifdef PIO_IRQ_TIMESTAMP_EN
    logic [TS_W-1:0]  last_ts;
    logic [TS_W-1:0]  tb_cyc;
`endif

    always #5 clk = ~clk;

    pio_irq_service_ctrl #(
        .CNT_W(CNT_W), .HOLDOFF(HOLDOFF), .READ_LATENCY(RL), .TS_W(TS_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .m_address(m_address),
        .m_chipselect(m_chipselect),
        .m_write_n(m_write_n),
        .m_writedata(m_writedata),
        .m_readdata(m_readdata),
        .pio_irq(pio_irq),
        .enable(enable),
        .event_pulse(event_pulse),
        .event_count(event_count),
        .spurious_count(spurious_count),
        .busy(busy)
`ifdef PIO_IRQ_TIMESTAMP_EN
        ,
        .last_ts(last_ts)
`endif
    );

    // PIO slave model
    logic        pio_cap, pio_mask, edge_evt, force_irq;
    logic [31:0] pio_data, pio_rd;
    logic [1:0]  wr_a[$];
    logic [31:0] wr_d[$];

    assign pio_irq    = (pio_cap & pio_mask) | force_irq;
    assign m_readdata = pio_rd;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pio_cap  <= 1'b0;
            pio_mask <= 1'b0;
            pio_data <= 32'd0;
            pio_rd   <= 32'd0;
        end else begin
            if (m_chipselect && !m_write_n) begin
                wr_a.push_back(m_address);
                wr_d.push_back(m_writedata);
                if (m_address == 2'd0) pio_data <= m_writedata;
                if (m_address == 2'd2) pio_mask <= m_writedata[0];
            end
            if (m_chipselect && !m_write_n && m_address == 2'd3)
                pio_cap <= 1'b0;
            else if (edge_evt)
                pio_cap <= 1'b1;
            case (m_address)
                2'd0:    pio_rd <= pio_data;
                2'd2:    pio_rd <= {31'd0, pio_mask};
                2'd3:    pio_rd <= {31'd0, pio_cap};
                default: pio_rd <= 32'd0;
            endcase
        end
    end

`ifdef PIO_IRQ_TIMESTAMP_EN
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tb_cyc <= '0;
        else          tb_cyc <= tb_cyc + 1'b1;
    end
`endif

    int checks = 0;
    int failures = 0;
    int exp_ev = 0;
    int exp_sp = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edge_in();
        edge_evt = 1'b1;
        step();
        edge_evt = 1'b0;
    endtask

    task automatic wait_pulse(input int budget, output int n);
        n = 0;
        while (!event_pulse && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        chk(tag, {63'd0, busy}, 64'd0);
    endtask

    task automatic wait_writes(input string tag, input int want);
        int n;
        n = 0;
        while (wr_a.size() < want && n < 30) begin
            step();
            n++;
        end
        chk(tag, 64'(wr_a.size() >= want), 64'd1);
    endtask

    // One edge from the IDLE state; expect the event 3 cycles after irq rises.
    task automatic service_edge(input string tag);
        int n;
        edge_in();
        chk({tag, "_irq"}, {63'd0, pio_irq}, 64'd1);
        wait_pulse(12, n);
        chk({tag, "_lat"}, 64'(n), 64'd3);
        exp_ev++;
        chk({tag, "_cnt"}, 64'(event_count), 64'(exp_ev % 16));
`ifdef PIO_IRQ_TIMESTAMP_EN
        chk({tag, "_ts"}, 64'(last_ts), 64'(tb_cyc - 1'b1));
`endif
        wait_idle({tag, "_idle"});
    endtask

    initial begin
        int n, nwr, snap, gap;
        enable = 1'b1;
        edge_evt = 1'b0;
        force_irq = 1'b0;
        reset_n = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_cs", {63'd0, m_chipselect}, 64'd0);
        chk("rst_wn", {63'd0, m_write_n}, 64'd1);
        chk("rst_addr", 64'(m_address), 64'd0);
        chk("rst_wd", 64'(m_writedata), 64'd0);
        chk("rst_pulse", {63'd0, event_pulse}, 64'd0);
        chk("rst_ev", 64'(event_count), 64'd0);
        chk("rst_sp", 64'(spurious_count), 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        reset_n = 1'b1;

        // Bring-up writes: clear capture, then mask on
        wait_writes("init_writes", 2);
        chk("init_w0_a", 64'(wr_a[0]), 64'd3);
        chk("init_w0_d", 64'(wr_d[0]), 64'd0);
        chk("init_w1_a", 64'(wr_a[1]), 64'd2);
        chk("init_w1_d", 64'(wr_d[1]), 64'd1);
        repeat (2) step();
        chk("init_busy", {63'd0, busy}, 64'd0);
        chk("init_mask", {63'd0, pio_mask}, 64'd1);
        chk("init_ev", 64'(event_count), 64'd0);
        $display("init: bring-up writes=%0d", wr_a.size());

        // Single edge
        service_edge("single");
        chk("single_cap", {63'd0, pio_cap}, 64'd0);
        chk("single_irq_low", {63'd0, pio_irq}, 64'd0);
        chk("single_clr_a", 64'(wr_a[wr_a.size()-1]), 64'd3);
        $display("single: event_count=%0d", event_count);

        // Spurious irq: capture reads 0, no clear write
        nwr = wr_a.size();
        force_irq = 1'b1;
        step();
        force_irq = 1'b0;
        repeat (8) step();
        exp_sp++;
        chk("spur_cnt", 64'(spurious_count), 64'(exp_sp));
        chk("spur_ev", 64'(event_count), 64'(exp_ev % 16));
        chk("spur_nowr", 64'(wr_a.size()), 64'(nwr));
        chk("spur_busy", {63'd0, busy}, 64'd0);
        $display("spurious: spurious_count=%0d", spurious_count);

        // Second edge during HOLD is kept and serviced once
        edge_in();
        wait_pulse(12, n);
        exp_ev++;
        chk("hold_first", 64'(event_count), 64'(exp_ev % 16));
        step();
        edge_in();
        wait_pulse(20, n);
        chk("hold_second_seen", {63'd0, event_pulse}, 64'd1);
        exp_ev++;
        chk("hold_second_cnt", 64'(event_count), 64'(exp_ev % 16));
        wait_idle("hold_idle");
        repeat (30) step();
        chk("hold_no_extra", 64'(event_count), 64'(exp_ev % 16));
        $display("hold: event_count=%0d", event_count);

        // Edge in the same cycle as the clear write is lost
        edge_in();
        wait_pulse(12, n);
        exp_ev++;
        edge_evt = 1'b1;
        step();
        edge_evt = 1'b0;
        repeat (30) step();
        chk("lost_cnt", 64'(event_count), 64'(exp_ev % 16));
        chk("lost_cap", {63'd0, pio_cap}, 64'd0);
        $display("lost-edge: event_count=%0d", event_count);

        // Random edge spacing and occasional spurious irqs; count wraps
        for (int i = 0; i < 20; i++) begin
            gap = $urandom_range(12, 25);
            repeat (gap) step();
            if ($urandom_range(0, 3) == 0) begin
                force_irq = 1'b1;
                step();
                force_irq = 1'b0;
                repeat (8) step();
                exp_sp++;
                chk("rnd_sp", 64'(spurious_count), 64'(exp_sp % 16));
            end
            service_edge("rnd");
            $display("rnd %0d: gap=%0d event_count=%0d spurious=%0d", i, gap, event_count, spurious_count);
        end

        // Disable: mask written off, edge latched but not serviced
        nwr = wr_a.size();
        enable = 1'b0;
        wait_writes("dis_write", nwr + 1);
        chk("dis_w_a", 64'(wr_a[nwr]), 64'd2);
        chk("dis_w_d", 64'(wr_d[nwr]), 64'd0);
        chk("dis_mask", {63'd0, pio_mask}, 64'd0);
        edge_in();
        repeat (20) step();
        chk("dis_ev", 64'(event_count), 64'(exp_ev % 16));
        chk("dis_busy", {63'd0, busy}, 64'd0);
        chk("dis_cap_held", {63'd0, pio_cap}, 64'd1);
        snap = exp_ev;
        enable = 1'b1;
        wait_pulse(20, n);
        exp_ev++;
        chk("reen_ev", 64'(event_count), 64'(exp_ev % 16));
        chk("reen_one", 64'(exp_ev - snap), 64'(event_count - CNT_W'(snap)));
        wait_idle("reen_idle");
        $display("re-enable: event_count=%0d", event_count);

        // Reset asserted during RD_CAP
        edge_in();
        n = 0;
        while (!(m_chipselect && m_write_n) && n < 10) begin
            step();
            n++;
        end
        chk("rdcap_seen", {63'd0, m_chipselect & m_write_n}, 64'd1);
        reset_n = 1'b0;
        #1;
        exp_ev = 0;
        exp_sp = 0;
        chk("arst_cs", {63'd0, m_chipselect}, 64'd0);
        chk("arst_wn", {63'd0, m_write_n}, 64'd1);
        chk("arst_ev", 64'(event_count), 64'd0);
        chk("arst_sp", 64'(spurious_count), 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        nwr = wr_a.size();
        repeat (2) step();
        reset_n = 1'b1;
        wait_writes("arst_writes", nwr + 2);
        chk("arst_w0_a", 64'(wr_a[nwr]), 64'd3);
        chk("arst_w1_a", 64'(wr_a[nwr+1]), 64'd2);
        repeat (2) step();
        service_edge("post_rst");
        $display("post-reset: event_count=%0d", event_count);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
